// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter: round-robin grant, one burst in flight, AR latched at grant.
// The latched address/length stay on the slave port for the whole burst.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0 (instruction fetch)
  input  logic [ADDR_WIDTH-1:0] m0_araddr_i,
  input  logic [LEN_WIDTH-1:0]  m0_arlen_i,
  input  logic                  m0_arvalid_i,
  output logic                  m0_arready_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic [1:0]            m0_rresp_o,
  output logic                  m0_rvalid_o,
  input  logic                  m0_rready_i,
  output logic                  m0_rlast_o,
  // requester 1 (data load)
  input  logic [ADDR_WIDTH-1:0] m1_araddr_i,
  input  logic [LEN_WIDTH-1:0]  m1_arlen_i,
  input  logic                  m1_arvalid_i,
  output logic                  m1_arready_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic [1:0]            m1_rresp_o,
  output logic                  m1_rvalid_o,
  input  logic                  m1_rready_i,
  output logic                  m1_rlast_o,
  // shared slave
  output logic [ADDR_WIDTH-1:0] s_araddr_o,
  output logic [LEN_WIDTH-1:0]  s_arlen_o,
  output logic                  s_arvalid_o,
  input  logic                  s_arready_i,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  input  logic [1:0]            s_rresp_i,
  input  logic                  s_rvalid_i,
  output logic                  s_rready_o,
  input  logic                  s_rlast_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;   // one-hot: bit0 = m0, bit1 = m1
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  pick_m1_s;
  logic                  rready_sel_s;

  // State, grant and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
    end
  end

  // Next-state, arbitration and datapath routing
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    m0_rdata_o   = '0;
    m0_rresp_o   = 2'b00;
    m0_rvalid_o  = 1'b0;
    m0_rlast_o   = 1'b0;
    m1_rdata_o   = '0;
    m1_rresp_o   = 2'b00;
    m1_rvalid_o  = 1'b0;
    m1_rlast_o   = 1'b0;
    s_araddr_o   = addr_q;
    s_arlen_o    = len_q;
    s_arvalid_o  = 1'b0;
    rready_sel_s = 1'b0;
    // on a tie the requester that was not served last wins
    pick_m1_s    = m1_arvalid_i && (!m0_arvalid_i || !last_grant_q);

    case (state_q)
      ST_IDLE: begin
        if (m0_arvalid_i || m1_arvalid_i) begin
          if (pick_m1_s) begin
            m1_arready_o = 1'b1;
            addr_d       = m1_araddr_i;
            len_d        = m1_arlen_i;
            grant_d      = 2'b10;
          end else begin
            m0_arready_o = 1'b1;
            addr_d       = m0_araddr_i;
            len_d        = m0_arlen_i;
            grant_d      = 2'b01;
          end
          state_d = ST_AR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        s_arvalid_o = 1'b1;
        if (s_arready_i) begin
          state_d = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (grant_q[0]) begin
          m0_rdata_o   = s_rdata_i;
          m0_rresp_o   = s_rresp_i;
          m0_rvalid_o  = s_rvalid_i;
          m0_rlast_o   = s_rlast_i;
          rready_sel_s = m0_rready_i;
        end else if (grant_q[1]) begin
          m1_rdata_o   = s_rdata_i;
          m1_rresp_o   = s_rresp_i;
          m1_rvalid_o  = s_rvalid_i;
          m1_rlast_o   = s_rlast_i;
          rready_sel_s = m1_rready_i;
        end else begin
          rready_sel_s = 1'b0;
        end
        s_rready_o = rready_sel_s;
        // the slave owns beat counting; rlast alone ends the burst
        if (s_rvalid_i && rready_sel_s && s_rlast_i) begin
          last_grant_d = grant_q[1];
          grant_d      = 2'b00;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_R;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase

    if (state_q != ST_R) begin
      s_rready_o = 1'b0;
    end else begin
      s_rready_o = rready_sel_s;
    end
  end

  axi_read_arbiter_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_arready_i (m0_arready_o),
    .m1_arready_i (m1_arready_o),
    .m0_rvalid_i  (m0_rvalid_o),
    .m1_rvalid_i  (m1_rvalid_o),
    .busy_i       (state_q != ST_IDLE),
    .grant_i      (grant_q),
    .addr_i       (s_araddr_o),
    .len_i        (s_arlen_o)
  );

endmodule

// Simulation-only protocol checks for the arbiter.
module axi_read_arbiter_chk #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  m0_arready_i,
  input logic                  m1_arready_i,
  input logic                  m0_rvalid_i,
  input logic                  m1_rvalid_i,
  input logic                  busy_i,
  input logic [1:0]            grant_i,
  input logic [ADDR_WIDTH-1:0] addr_i,
  input logic [LEN_WIDTH-1:0]  len_i
);

  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;

  // Previous-cycle copy of the slave request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      busy_q <= busy_i;
      addr_q <= addr_i;
      len_q  <= len_i;
    end
  end

  // Invariant checks sampled on every rising edge out of reset
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(m0_arready_i && m1_arready_i))
        else $error("FAIL chk_arready both requesters acknowledged");
      assert (!busy_q || (addr_i == addr_q && len_i == len_q))
        else $error("FAIL chk_stable addr=%0h/%0h len=%0h/%0h", addr_i, addr_q, len_i, len_q);
      assert ((!m0_rvalid_i || grant_i[0]) && (!m1_rvalid_i || grant_i[1]))
        else $error("FAIL chk_rvalid_grant grant=%0b", grant_i);
    end
  end

endmodule
